// File: rtl/vector_player_checker_pkg.sv
// rtl/vector_player_checker_pkg.sv - shared state encoding and entry field layout
package vector_player_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Entries pack {inputs, expected}: expected sits at bit 0, inputs start at OUT_W.
  localparam int EXP_LSB = 0;

endpackage

// File: rtl/vector_player_checker_if.sv
// rtl/vector_player_checker_if.sv - load, control, status and block-under-test signals
interface vector_player_checker_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DEPTH = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                   load_en;
  logic [IDX_W-1:0]       load_addr;
  logic [IN_W+OUT_W-1:0]  load_data;
  logic                   start;
  logic [IN_W-1:0]        dut_in;
  logic [OUT_W-1:0]       dut_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [IDX_W:0]         tests_run;
  logic [IDX_W:0]         err_count;
  logic                   first_fail_valid;
  logic [IDX_W-1:0]       first_fail_idx;

  modport master (
    output load_en, load_addr, load_data, start, dut_out,
    input  dut_in, busy, done, pass, tests_run, err_count,
           first_fail_valid, first_fail_idx
  );

  modport slave (
    input  load_en, load_addr, load_data, start, dut_out,
    output dut_in, busy, done, pass, tests_run, err_count,
           first_fail_valid, first_fail_idx
  );
endinterface

// File: rtl/vector_player_checker_vector_table.sv
// rtl/vector_player_checker_vector_table.sv - vector storage with per-entry valid flags
module vector_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  // Data is deliberately not reset; only the valid flags decide what a run sees.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset)  valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  end

  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];
endmodule

// File: rtl/vector_player_checker.sv
// rtl/vector_player_checker.sv - plays stored vectors into a block and checks its output
module vector_player_checker
  import vector_player_checker_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  vector_player_checker_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int ENT_W = IN_W + OUT_W;
  localparam logic [IDX_W:0] IDX_END = (IDX_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic [IN_W-1:0]  din_q, din_d;
  logic [IDX_W:0]   tests_q, tests_d;
  logic [IDX_W:0]   err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;

  logic [ENT_W-1:0] ent_data;
  logic             ent_valid;
  logic             tbl_we;

  assign tbl_we = bus.load_en && (state_q == IDLE || state_q == DONE);

  vector_table #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (tbl_we),
    .waddr  (bus.load_addr),
    .wdata  (bus.load_data),
    .raddr  (idx_q[IDX_W-1:0]),
    .rdata  (ent_data),
    .rvalid (ent_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      din_q   <= '0;
      tests_q <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      din_q   <= din_d;
      tests_q <= tests_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    din_d   = din_q;
    tests_d = tests_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          tests_d = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        // The index check must come first: at DEPTH the table address wraps.
        if (idx_q == IDX_END || !ent_valid) begin
          state_d = DONE;
        end else begin
          din_d   = ent_data[ENT_W-1 -: IN_W];
          exp_d   = ent_data[EXP_LSB +: OUT_W];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bus.dut_out !== exp_q) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q[IDX_W-1:0];
          end
        end
        tests_d = tests_q + 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dut_in           = din_q;
  assign bus.busy             = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done             = (state_q == DONE);
  assign bus.pass             = (state_q == DONE) && (err_q == '0);
  assign bus.tests_run        = tests_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;
endmodule
